rr_select_arbiter_2b: RTL and testbench

- Four-way round-robin request arbiter that produces a registered 2-bit grant index plus a grant-valid qualifier.
- Sits directly upstream of the 2-to-4 decoder: gnt_idx drives the decoder select, and gnt_valid gates the decoder's one-hot output downstream.
- Grants are held until the requester signals done, drops its request, or hits a hold timeout. A one-cycle release gap follows every grant (break-before-make).

---
 rtl/rr_select_arbiter_2b.sv | 119 +++++++++++
 tb/tb_rr_select_arbiter_2b.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/rr_select_arbiter_2b.sv
// rr_select_arbiter_2b
//   Four-way round-robin arbiter. It produces a registered 2-bit grant index
//   and a grant-valid qualifier that feed a downstream 2-to-4 decoder.
//   A grant is held until one of these events occurs: the holder signals done,
//   the holder drops its request, or the hold limit expires. Every grant is
//   followed by a one-cycle release gap (break-before-make).
//
// Ports
//   clk               system clock, rising edge
//   rst_n             asynchronous active-low reset
//   i_req[3:0]        request vector, bit i = requester i
//   i_done            grant holder finished; only looked at while granted
//   o_gnt_idx[1:0]    registered grant index (decoder select)
//   o_gnt_valid       registered, high while o_gnt_idx is a live grant
//   o_timeout_pulse   registered one-cycle pulse on a forced release
//   o_busy            registered, high in GRANT and RELEASE
module rr_select_arbiter_2b #(
  parameter int unsigned HOLD_MAX = 16,
  parameter int unsigned CNT_W    = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] i_req,
  input  logic       i_done,
  output logic [1:0] o_gnt_idx,
  output logic       o_gnt_valid,
  output logic       o_timeout_pulse,
  output logic       o_busy
);

  typedef enum logic [1:0] {StIdle, StGrant, StRelease} state_e;

  // Last hold_cnt value a grant may reach before it is forced off.
  localparam logic [CNT_W-1:0] HoldLast = CNT_W'(HOLD_MAX - 1);

  state_e           r_state;
  logic [1:0]       r_gnt_idx;
  logic [1:0]       r_last_ptr;
  logic             r_gnt_valid;
  logic             r_timeout_pulse;
  logic             r_busy;
  logic [CNT_W-1:0] r_hold_cnt;

  logic [1:0]       w_winner;
  logic [1:0]       w_cand;
  logic             w_found;
  logic             w_any_req;

  assign w_any_req = |i_req;

  // Search starts one past the last winner and wraps mod 4. At k=4 the
  // search reaches the last winner itself.
  always_comb begin
    w_winner = r_last_ptr;
    w_found  = 1'b0;
    w_cand   = '0;
    for (int k = 1; k <= 4; k++) begin
      w_cand = r_last_ptr + 2'(k);
      if (!w_found && i_req[w_cand]) begin
        w_winner = w_cand;
        w_found  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= StIdle;
      r_gnt_idx       <= 2'b00;
      r_last_ptr      <= 2'b11;
      r_gnt_valid     <= 1'b0;
      r_timeout_pulse <= 1'b0;
      r_busy          <= 1'b0;
      r_hold_cnt      <= '0;
    end else begin
      r_timeout_pulse <= 1'b0;
      unique case (r_state)
        StIdle, StRelease: begin
          if (w_any_req) begin
            r_state     <= StGrant;
            r_gnt_idx   <= w_winner;
            r_last_ptr  <= w_winner;
            r_gnt_valid <= 1'b1;
            r_busy      <= 1'b1;
            r_hold_cnt  <= '0;
          end else begin
            r_state     <= StIdle;
            r_gnt_valid <= 1'b0;
            r_busy      <= 1'b0;
          end
        end
        StGrant: begin
          // done beats a request drop, which beats the timeout.
          if (i_done || !i_req[r_gnt_idx]) begin
            r_state     <= StRelease;
            r_gnt_valid <= 1'b0;
          end else if (r_hold_cnt == HoldLast) begin
            r_state         <= StRelease;
            r_gnt_valid     <= 1'b0;
            r_timeout_pulse <= 1'b1;
          end else begin
            r_hold_cnt <= r_hold_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_state     <= StIdle;
          r_gnt_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign o_gnt_idx       = r_gnt_idx;
  assign o_gnt_valid     = r_gnt_valid;
  assign o_timeout_pulse = r_timeout_pulse;
  assign o_busy          = r_busy;

endmodule

// File: tb/tb_rr_select_arbiter_2b.sv
module tb_rr_select_arbiter_2b;

  localparam int HoldMax = 16;

  logic       clk;
  logic       rst_n;
  logic [3:0] i_req;
  logic       i_done;
  logic [1:0] o_gnt_idx;
  logic       o_gnt_valid;
  logic       o_timeout_pulse;
  logic       o_busy;

  int vectors;
  int miscompares;

  rr_select_arbiter_2b #(
    .HOLD_MAX(HoldMax),
    .CNT_W   (5)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_req          (i_req),
    .i_done         (i_done),
    .o_gnt_idx      (o_gnt_idx),
    .o_gnt_valid    (o_gnt_valid),
    .o_timeout_pulse(o_timeout_pulse),
    .o_busy         (o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: phase 0 idle, 1 granted, 2 release gap.
  // held counts the cycles the current grant has been visible.
  int m_phase;
  int m_idx;
  int m_last;
  int m_held;
  bit m_pulse;

  function automatic int rr_pick(input logic [3:0] req, input int last);
    for (int k = 1; k <= 4; k++) begin
      if (req[(last + k) % 4]) return (last + k) % 4;
    end
    return last;
  endfunction

  task automatic model_reset();
    m_phase = 0;
    m_idx   = 0;
    m_last  = 3;
    m_held  = 0;
    m_pulse = 1'b0;
  endtask

  task automatic model_edge(input logic [3:0] req, input logic done);
    m_pulse = 1'b0;
    if (m_phase == 1) begin
      if (done || !req[m_idx]) begin
        m_phase = 2;
      end else if (m_held == HoldMax) begin
        m_phase = 2;
        m_pulse = 1'b1;
      end else begin
        m_held++;
      end
    end else if (req != 4'b0000) begin
      m_idx   = rr_pick(req, m_last);
      m_last  = m_idx;
      m_phase = 1;
      m_held  = 1;
    end else begin
      m_phase = 0;
    end
  endtask

  task automatic cmp(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    cmp({tag, ".idx"},   {2'b00, o_gnt_idx},       4'(m_idx));
    cmp({tag, ".valid"}, {3'b000, o_gnt_valid},    {3'b000, m_phase == 1});
    cmp({tag, ".busy"},  {3'b000, o_busy},         {3'b000, m_phase != 0});
    cmp({tag, ".pulse"}, {3'b000, o_timeout_pulse}, {3'b000, m_pulse});
  endtask

  // Drive inputs, take one clock edge, advance the model, sample 1 time unit later.
  task automatic step(input logic [3:0] req, input logic done, input string tag);
    i_req  = req;
    i_done = done;
    @(posedge clk);
    model_edge(req, done);
    #1;
    check_model(tag);
  endtask

  int         vcnt;
  int         pulses;
  logic [3:0] rnd_req;
  logic [1:0] exp_seq [4];

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    i_req       = 4'b0000;
    i_done      = 1'b0;
    model_reset();
    #1;
    check_model("reset");
    @(posedge clk);
    #1;
    check_model("reset_hold");
    rst_n = 1'b1;

    // 1: first grant goes to index 0, one edge after req is sampled.
    step(4'b1111, 1'b0, "t1");
    cmp("t1.first_idx", {2'b00, o_gnt_idx}, 4'd0);
    cmp("t1.first_valid", {3'b000, o_gnt_valid}, 4'd1);

    // 2: rotation 0,1,2,3,0 with a single gap cycle between grants.
    exp_seq[0] = 2'd1;
    exp_seq[1] = 2'd2;
    exp_seq[2] = 2'd3;
    exp_seq[3] = 2'd0;
    for (int i = 0; i < 4; i++) begin
      step(4'b1111, 1'b1, "t2.gap");
      cmp("t2.gap_valid", {3'b000, o_gnt_valid}, 4'd0);
      step(4'b1111, 1'b0, "t2.grant");
      cmp("t2.rot_idx", {2'b00, o_gnt_idx}, {2'b00, exp_seq[i]});
    end

    // 3: grant 1, then req=1001 gives 3 and wraps to 0.
    step(4'b1111, 1'b1, "t3");
    step(4'b1111, 1'b0, "t3");
    cmp("t3.idx1", {2'b00, o_gnt_idx}, 4'd1);
    step(4'b1001, 1'b1, "t3");
    step(4'b1001, 1'b0, "t3");
    cmp("t3.idx3", {2'b00, o_gnt_idx}, 4'd3);
    step(4'b1001, 1'b1, "t3");
    step(4'b1001, 1'b0, "t3");
    cmp("t3.wrap0", {2'b00, o_gnt_idx}, 4'd0);

    // 4: lone requester 2 times out after HoldMax visible cycles.
    step(4'b0100, 1'b0, "t4.drop");
    step(4'b0100, 1'b0, "t4.grant");
    cmp("t4.idx2", {2'b00, o_gnt_idx}, 4'd2);
    vcnt   = o_gnt_valid ? 1 : 0;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      step(4'b0100, 1'b0, "t4.hold");
      if (o_gnt_valid) begin
        vcnt++;
      end else begin
        if (o_timeout_pulse) pulses++;
        break;
      end
    end
    cmp("t4.valid_cycles", 4'(vcnt), 4'(HoldMax));
    cmp("t4.pulse_seen", 4'(pulses), 4'd1);
    step(4'b0100, 1'b0, "t4.regrant");
    cmp("t4.regrant_idx", {2'b00, o_gnt_idx}, 4'd2);
    cmp("t4.pulse_one_cycle", {3'b000, o_timeout_pulse}, 4'd0);

    // 5: done on the last hold cycle wins over the timeout.
    for (int i = 0; i < HoldMax - 1; i++) step(4'b0100, 1'b0, "t5.hold");
    step(4'b0100, 1'b1, "t5.done_last");
    cmp("t5.no_pulse", {3'b000, o_timeout_pulse}, 4'd0);
    cmp("t5.released", {3'b000, o_gnt_valid}, 4'd0);
    step(4'b0100, 1'b0, "t5.regrant");
    step(4'b0100, 1'b0, "t5.hold2");
    step(4'b0000, 1'b0, "t5.req_drop");
    cmp("t5.drop_valid", {3'b000, o_gnt_valid}, 4'd0);
    cmp("t5.drop_pulse", {3'b000, o_timeout_pulse}, 4'd0);
    step(4'b0000, 1'b0, "t5.idle");
    cmp("t5.idle_busy", {3'b000, o_busy}, 4'd0);

    // 6: asynchronous reset mid-grant, then the pointer restarts at 0.
    step(4'b1111, 1'b0, "t6.grant");
    step(4'b1111, 1'b0, "t6.hold");
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_model("t6.async_rst");
    cmp("t6.rst_idx", {2'b00, o_gnt_idx}, 4'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step(4'b1111, 1'b0, "t6.first");
    cmp("t6.first_idx", {2'b00, o_gnt_idx}, 4'd0);

    // Random traffic against the model; requests tend to persist.
    rnd_req = 4'($urandom_range(0, 15));
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) rnd_req = 4'($urandom_range(0, 15));
      step(rnd_req, $urandom_range(0, 9) == 0, "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
